drawing_sequencer: RTL and testbench
====================================

# drawing_sequencer

Controller FSM that sequences the cell-drawing datapath by driving its 3-bit state input. It arbitrates between clear, cursor-move, draw and erase requests, runs the MOVE→WAIT→CLEAN cursor-animation sequence, and guards every datapath phase with a timeout. It sits between the input-decode logic (buttons/keyboard) and the drawing datapath, and is the only driver of the datapath's state input.

## Interface
- WAIT_CYCLES, 4, cycles spent in WAIT between cursor draw and old-cursor clean (used only with DRAW_SEQ_WAIT_DELAY_EN).
- TIMEOUT_CYCLES, 1024, max cycles in a busy state without iDone before abort.

- iClk  in  1  clock.
- iResetn  in  1  reset, asynchronous, active-low.
- iClear  in  1  clear-screen button level, active-high, synchronous to iClk.
- iDraw  in  1  draw button level.
- iErase  in  1  erase button level.
- iMove  in  1  datapath move flag: cursor cell differs from last cleaned cell.
- iDone  in  1  datapath phase-complete flag.
- oState  out  3  datapath state: IDLE 0, MOVE 1, WAIT 2, CLEAN 3, DRAW 4, ERASE 5, CLEAR 6.
- oBusy  out  1  high whenever oState ≠ IDLE.
- oCleared  out  1  one-cycle pulse when CLEAR completes.
- oError  out  1  sticky timeout flag.

## Operation
- All outputs registered. Reset: oState=IDLE, oBusy=0, oCleared=0, oError=0, painted=0, counters=0, iClear edge register=0.
- Clear is edge-triggered: registered previous iClear; request = iClear & ~prev. Draw/erase are level requests gated by internal painted flag (one paint per cell visit).
- IDLE priority: clear edge → CLEAR; else iMove → MOVE; else iDraw & ~painted → DRAW; else iErase & ~painted → ERASE; else stay. Draw wins over erase when both held.
- MOVE: iDone → WAIT. WAIT: delay expires → CLEAN. CLEAN: iDone → IDLE, painted←0.
- DRAW, ERASE: iDone → IDLE, painted←1. CLEAR: iDone → IDLE, painted←0, oCleared=1 for one cycle.
- iDone ignored in the first cycle of every busy state (datapath clears its flag one edge late).
- Timeout: counter reset on every state entry, increments each cycle in MOVE/CLEAN/DRAW/ERASE/CLEAR; reaching TIMEOUT_CYCLES−1 without accepted iDone → IDLE, oError←1 (until reset), painted unchanged. WAIT never times out.
- Clear edge arriving while busy is dropped (not queued); MOVE/DRAW/ERASE requests are levels so retry naturally.
- Counter widths: $clog2(WAIT_CYCLES+1), $clog2(TIMEOUT_CYCLES+1); no wrap (saturates at limit).

## Timing
- Request sampled in IDLE at edge N → oState new value after edge N, oBusy high same cycle.
- Accepted iDone at edge N → next state visible after edge N; minimum busy-state length 2 cycles.
- WAIT length: exactly WAIT_CYCLES cycles (macro on) or 1 cycle (macro off).
- oCleared high in the first IDLE cycle after CLEAR.
- Async reset mid-phase: immediate return to reset values; no completion pulse.

## Configuration
- DRAW_SEQ_WAIT_DELAY_EN: defined → WAIT holds for WAIT_CYCLES via down-counter loaded on MOVE exit. Undefined → counter not built, WAIT lasts one cycle, WAIT_CYCLES ignored.

## Test plan
- Reset, then iMove=1 held, iDone pulsed in MOVE at cycle 3 and in CLEAN at cycle 3 (macro on, WAIT_CYCLES=4) → oState 0,1,1,1,2,2,2,2,3,3,3,0.
- iDraw held, iDone after 2 cycles in DRAW → exactly one DRAW visit; oState stays 0 afterward until iMove sequence completes, then DRAW re-entered once.
- iDraw and iErase both held in IDLE → DRAW (4) chosen, ERASE never entered.
- iClear held 10 cycles while IDLE, iDone at cycle 2 of CLEAR → single CLEAR visit, oCleared=1 for exactly one cycle, no second CLEAR.
- DRAW entered, iDone never asserted, TIMEOUT_CYCLES=16 → return to IDLE after 16 cycles, oError=1 and stays 1 through further traffic until iResetn low.
- iResetn pulsed low during CLEAN → oState=0, oBusy=0, oError=0 asynchronously; macro off build: WAIT visible for exactly 1 cycle.

Source files
------------

// File: rtl/drawing_sequencer_if.sv
// drawing_sequencer_if: request/status bundle shared by input decode, datapath and sequencer
//   iClear/iDraw/iErase : button-level requests from input decode
//   iMove/iDone         : datapath flags (cursor moved, phase complete)
//   oState              : datapath state code driven by the sequencer
//   oBusy/oCleared/oError : sequencer status
//   master: drives requests and flags, observes status; slave: the sequencer
interface drawing_sequencer_if;
    logic       iClear;
    logic       iDraw;
    logic       iErase;
    logic       iMove;
    logic       iDone;
    logic [2:0] oState;
    logic       oBusy;
    logic       oCleared;
    logic       oError;
    modport master (output iClear, iDraw, iErase, iMove, iDone, input oState, oBusy, oCleared, oError);
    modport slave  (input iClear, iDraw, iErase, iMove, iDone, output oState, oBusy, oCleared, oError);
endinterface

// File: rtl/drawing_sequencer.sv
// drawing_sequencer: arbitrates clear/move/draw/erase and sequences the cell-drawing datapath
//   iClk    : clock
//   iResetn : asynchronous active-low reset
//   bus     : drawing_sequencer_if.slave (requests, datapath flags, oState/oBusy/oCleared/oError)
//   Optional macro DRAW_SEQ_WAIT_DELAY_EN: WAIT holds for WAIT_CYCLES, otherwise WAIT is one cycle.
module drawing_sequencer #(
    parameter int unsigned WAIT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                iClk,
    input logic                iResetn,
    drawing_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        WAIT  = 3'd2,
        CLEAN = 3'd3,
        DRAW  = 3'd4,
        ERASE = 3'd5,
        CLEAR = 3'd6
    } state_t;
    state_t        r_state, w_state;
    logic          r_busy, r_cleared, r_error, r_painted, r_clr_prev;
    logic          w_cleared, w_error, w_painted;
    logic [TW-1:0] r_tmo, w_tmo;
    logic          w_clr_req, w_done, w_timeout, w_wait_over;
    if (WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("drawing_sequencer: WAIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end
`ifdef DRAW_SEQ_WAIT_DELAY_EN
    localparam int WW = $clog2(WAIT_CYCLES + 1);
    logic [WW-1:0] r_wait;
    // Reloaded every MOVE cycle so the value present on MOVE exit is the full delay.
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn)
            r_wait <= '0;
        else if (r_state == MOVE)
            r_wait <= WW'(WAIT_CYCLES - 1);
        else if (r_wait != '0)
            r_wait <= r_wait - 1'b1;
    end
    assign w_wait_over = (r_wait == '0);
`else
    assign w_wait_over = 1'b1;
`endif
    assign w_clr_req = bus.iClear & ~r_clr_prev;
    // The timeout counter is zero only in the first cycle of a busy state, where the
    // datapath's done flag is still stale from the previous phase.
    assign w_done    = bus.iDone & (r_tmo != '0);
    assign w_timeout = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    always_comb begin
        w_state   = r_state;
        w_painted = r_painted;
        w_cleared = 1'b0;
        w_error   = r_error;
        case (r_state)
            IDLE: w_state = w_clr_req ? CLEAR :
                            bus.iMove ? MOVE :
                            (bus.iDraw & ~r_painted) ? DRAW :
                            (bus.iErase & ~r_painted) ? ERASE : IDLE;
            WAIT: w_state = w_wait_over ? CLEAN : WAIT;
            default: begin
                if (w_done) begin
                    w_state   = (r_state == MOVE) ? WAIT : IDLE;
                    w_painted = (r_state == MOVE) ? r_painted : (r_state == DRAW || r_state == ERASE);
                    w_cleared = (r_state == CLEAR);
                end else if (w_timeout) begin
                    w_state = IDLE;
                    w_error = 1'b1;
                end
            end
        endcase
        w_tmo = (w_state != r_state || r_state == IDLE || r_state == WAIT) ? '0 :
                (r_tmo == TW'(TIMEOUT_CYCLES)) ? r_tmo : r_tmo + 1'b1;
    end
    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_cleared  <= 1'b0;
            r_error    <= 1'b0;
            r_painted  <= 1'b0;
            r_clr_prev <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state;
            r_busy     <= (w_state != IDLE);
            r_cleared  <= w_cleared;
            r_error    <= w_error;
            r_painted  <= w_painted;
            r_clr_prev <= bus.iClear;
            r_tmo      <= w_tmo;
        end
    end
    assign bus.oState   = r_state;
    assign bus.oBusy    = r_busy;
    assign bus.oCleared = r_cleared;
    assign bus.oError   = r_error;
endmodule

// File: tb/tb_drawing_sequencer.sv
// tb_drawing_sequencer: directed and randomized transactions checked against a phase-level model
module tb_drawing_sequencer;
    localparam int WAIT_N = 4;
    localparam int TMO_N  = 16;
`ifdef DRAW_SEQ_WAIT_DELAY_EN
    localparam int WAIT_LEN = WAIT_N;
`else
    localparam int WAIT_LEN = 1;
`endif
    logic iClk    = 1'b0;
    logic iResetn = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   m_painted, m_error, m_cleared;
    drawing_sequencer_if bus();
    drawing_sequencer #(.WAIT_CYCLES(WAIT_N), .TIMEOUT_CYCLES(TMO_N)) dut (
        .iClk(iClk),
        .iResetn(iResetn),
        .bus(bus)
    );
    always #5 iClk = ~iClk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask
    // n cycles expected in state st; iDone optionally in the last and/or first cycle
    task automatic phase(input int st, input int n, input bit done_last, input bit done_first);
        for (int i = 0; i < n; i++) begin
            bus.iDone = (done_last && i == n - 1) || (done_first && i == 0);
            check($sformatf("state%0d[%0d]", st, i), bus.oState, st);
            check("busy", bus.oBusy, st != 0);
            check("cleared", bus.oCleared, m_cleared);
            check("error", bus.oError, m_error);
            m_cleared = 1'b0;
            tick();
        end
        bus.iDone = 1'b0;
    endtask
    task automatic idle(input int n);
        phase(0, n, 1'b0, 1'b0);
    endtask
    // One busy-state visit: completes with iDone on its n-th cycle, or times out after TMO_N cycles
    task automatic visit(input int st, input int n, input bit done, input bit early);
        phase(st, done ? n : TMO_N, done, early);
        if (!done) m_error = 1'b1;
        else if (st == 4 || st == 5) m_painted = 1'b1;
        else if (st == 3 || st == 6) m_painted = 1'b0;
        if (done && st == 6) m_cleared = 1'b1;
        if (done && st == 1) phase(2, WAIT_LEN, 1'b0, 1'b0);
    endtask
    task automatic cursor(input int m, input int c);
        bus.iMove = 1'b1;
        idle(1);
        visit(1, m, 1'b1, 1'b0);
        bus.iMove = 1'b0;
        visit(3, c, 1'b1, 1'b0);
    endtask
    initial begin
        bus.iClear = 0; bus.iDraw = 0; bus.iErase = 0; bus.iMove = 0; bus.iDone = 0;
        m_painted = 0; m_error = 0; m_cleared = 0;
        #12;
        check("rst_state", bus.oState, 0);
        check("rst_busy", bus.oBusy, 0);
        check("rst_cleared", bus.oCleared, 0);
        check("rst_error", bus.oError, 0);
        @(negedge iClk) iResetn = 1'b1;
        tick();
        // cursor animation: 0,1,1,1,2..,3,3,3,0
        cursor(3, 3);
        idle(2);
        // one paint per cell visit; first-cycle iDone ignored
        bus.iDraw = 1;
        idle(1);
        visit(4, 2, 1'b1, 1'b1);
        idle(4);
        bus.iErase = 1;
        idle(2);
        bus.iErase = 0;
        cursor(2, 2);
        idle(1);
        visit(4, 3, 1'b1, 1'b0);
        bus.iDraw = 0;
        idle(2);
        // draw wins over erase
        cursor(2, 2);
        bus.iDraw = 1; bus.iErase = 1;
        idle(1);
        visit(4, 2, 1'b1, 1'b0);
        idle(3);
        bus.iDraw = 0; bus.iErase = 0;
        cursor(2, 2);
        bus.iErase = 1;
        idle(1);
        visit(5, 3, 1'b1, 1'b0);
        bus.iErase = 0;
        idle(1);
        // clear held 10 cycles: one CLEAR, one pulse
        bus.iClear = 1;
        idle(1);
        visit(6, 2, 1'b1, 1'b0);
        idle(7);
        bus.iClear = 0;
        idle(1);
        // clear edge while busy is dropped
        bus.iDraw = 1;
        idle(1);
        bus.iDraw = 0;
        bus.iClear = 1;
        visit(4, 4, 1'b1, 1'b0);
        idle(3);
        bus.iClear = 0;
        idle(1);
        // iDone on the last allowed cycle beats the timeout
        cursor(2, 2);
        bus.iDraw = 1;
        idle(1);
        bus.iDraw = 0;
        visit(4, TMO_N, 1'b1, 1'b0);
        idle(2);
        // timeout: sticky error, painted unchanged
        cursor(2, 2);
        bus.iDraw = 1;
        idle(1);
        bus.iDraw = 0;
        visit(4, TMO_N, 1'b0, 1'b1);
        idle(2);
        cursor(3, 3);
        bus.iDraw = 1;
        idle(1);
        bus.iDraw = 0;
        visit(4, 2, 1'b1, 1'b0);
        idle(2);
        // asynchronous reset in the middle of CLEAN
        bus.iMove = 1;
        idle(1);
        visit(1, 2, 1'b1, 1'b0);
        bus.iMove = 0;
        phase(3, 2, 1'b0, 1'b0);
        #2 iResetn = 1'b0;
        #1;
        check("arst_state", bus.oState, 0);
        check("arst_busy", bus.oBusy, 0);
        check("arst_error", bus.oError, 0);
        check("arst_cleared", bus.oCleared, 0);
        m_error = 0; m_painted = 0; m_cleared = 0;
        @(negedge iClk) iResetn = 1'b1;
        tick();
        idle(2);
        // randomized request mixes
        for (int t = 0; t < 40; t++) begin
            bit rc, rm, rd, re, to, early;
            int pick;
            rc    = ($urandom_range(0, 3) == 0);
            rm    = ($urandom_range(0, 2) == 0);
            rd    = $urandom_range(0, 1) == 1;
            re    = $urandom_range(0, 1) == 1;
            to    = ($urandom_range(0, 7) == 0);
            early = $urandom_range(0, 1) == 1;
            pick  = rc ? 6 : rm ? 1 : (rd && !m_painted) ? 4 : (re && !m_painted) ? 5 : 0;
            bus.iClear = rc; bus.iMove = rm; bus.iDraw = rd; bus.iErase = re;
            idle(1);
            bus.iClear = 0; bus.iMove = 0; bus.iDraw = 0; bus.iErase = 0;
            if (pick != 0) begin
                visit(pick, $urandom_range(2, 8), !to, early);
                if (pick == 1 && !to) visit(3, $urandom_range(2, 8), 1'b1, 1'b0);
            end
            idle(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
